// File: rtl/padding_fifo_thresh.sv
// Synchronous FIFO with an inferred RAM, programmable fill/free watermarks, a soft
// clear, an exposed fill level and sticky overflow/underflow flags.
module padding_fifo_thresh #(
    parameter int WIDTH     = 256,
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [WIDTH-1:0]     din,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    input  logic [ADDR_BITS:0]   m_count,
    output logic                 m_ready,
    input  logic [ADDR_BITS:0]   s_count,
    output logic                 s_ready,
    output logic [ADDR_BITS:0]   data_count,
    output logic                 full,
    output logic                 empty,
    output logic                 ovf_err,
    output logic                 udf_err
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    localparam logic [ADDR_BITS-1:0] PTR_ZERO  = {ADDR_BITS{1'b0}};
    localparam logic [ADDR_BITS-1:0] PTR_ONE   = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0]   CNT_ZERO  = {(ADDR_BITS+1){1'b0}};
    localparam logic [ADDR_BITS:0]   CNT_ONE   = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0]   CNT_FULL  = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS+1:0] DEPTH_EXT = {2'b01, {ADDR_BITS{1'b0}}};

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic [ADDR_BITS+1:0] free_s;
    logic [WIDTH-1:0]     dout_q;
    logic                 dout_valid_q, dout_valid_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 m_ready_q, m_ready_d;
    logic                 s_ready_q, s_ready_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 wr_acc_s, rd_acc_s;

    // Next-state pointers, fill level, flags and error bits.
    always_comb begin
        // Full/empty are the registered start-of-cycle values, so a same-cycle read
        // never makes room for a write.
        wr_acc_s     = wr_en && !full_q;
        rd_acc_s     = rd_en && !empty_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dout_valid_d = 1'b0;
        ovf_d        = ovf_q;
        udf_d        = udf_q;
        if (clr) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_acc_s) begin
                rd_ptr_d     = rd_ptr_q + PTR_ONE;
                dout_valid_d = 1'b1;
            end else begin
                rd_ptr_d     = rd_ptr_q;
                dout_valid_d = 1'b0;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (wr_en && full_q) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
            if (rd_en && empty_q) begin
                udf_d = 1'b1;
            end else begin
                udf_d = udf_q;
            end
        end
        // One extra bit keeps DEPTH - count from wrapping before the compare.
        free_s    = DEPTH_EXT - {1'b0, count_d};
        m_ready_d = (count_d >= m_count);
        s_ready_d = (free_s >= {1'b0, s_count});
        full_d    = (count_d == CNT_FULL);
        empty_d   = (count_d == CNT_ZERO);
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= PTR_ZERO;
            rd_ptr_q     <= PTR_ZERO;
            count_q      <= CNT_ZERO;
            dout_valid_q <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            m_ready_q    <= 1'b0;
            s_ready_q    <= 1'b1;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_valid_q <= dout_valid_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            m_ready_q    <= m_ready_d;
            s_ready_q    <= s_ready_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
        end
    end

    // Registered read port; dout holds its value unless a read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= {WIDTH{1'b0}};
        end else if (rd_acc_s && !clr) begin
            dout_q <= mem_q[rd_ptr_q];
        end else begin
            dout_q <= dout_q;
        end
    end

    // RAM write port, contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !clr && !rst) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign m_ready    = m_ready_q;
    assign s_ready    = s_ready_q;
    assign data_count = count_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign ovf_err    = ovf_q;
    assign udf_err    = udf_q;

endmodule

// File: tb/tb_padding_fifo_thresh.sv
// Directed bench for padding_fifo_thresh (WIDTH=8, DEPTH=16) with a queue-based
// reference model compared every cycle, plus hand-computed spot checks.
module tb_padding_fifo_thresh;

    localparam int WIDTH     = 8;
    localparam int ADDR_BITS = 4;
    localparam int DEPTH     = 16;

    logic                 clk;
    logic                 rst;
    logic                 clr;
    logic [WIDTH-1:0]     din;
    logic                 wr_en;
    logic                 rd_en;
    logic [WIDTH-1:0]     dout;
    logic                 dout_valid;
    logic [ADDR_BITS:0]   m_count;
    logic                 m_ready;
    logic [ADDR_BITS:0]   s_count;
    logic                 s_ready;
    logic [ADDR_BITS:0]   data_count;
    logic                 full;
    logic                 empty;
    logic                 ovf_err;
    logic                 udf_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout;
    bit               m_dv, m_ovf, m_udf, m_mr, m_sr;

    padding_fifo_thresh #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .m_count(m_count), .m_ready(m_ready),
        .s_count(s_count), .s_ready(s_ready), .data_count(data_count), .full(full),
        .empty(empty), .ovf_err(ovf_err), .udf_err(udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO as a queue, flags derived from its size at each edge.
    always @(posedge clk) begin
        bit wok, rok;
        if (rst) begin
            q.delete();
            m_dout = 8'h00; m_dv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
            m_mr = 1'b0; m_sr = 1'b1;
        end else if (clr) begin
            q.delete();
            m_dv = 1'b0;
            m_mr = (0 >= int'(m_count));
            m_sr = (DEPTH >= int'(s_count));
        end else begin
            wok = wr_en && (q.size() < DEPTH);
            rok = rd_en && (q.size() > 0);
            if (wr_en && !wok) m_ovf = 1'b1;
            if (rd_en && !rok) m_udf = 1'b1;
            m_dv = rok;
            if (rok) m_dout = q.pop_front();
            if (wok) q.push_back(din);
            m_mr = (q.size() >= int'(m_count));
            m_sr = ((DEPTH - q.size()) >= int'(s_count));
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_count", 32'(data_count), 32'(q.size()));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("m_ready", 32'(m_ready), 32'(m_mr));
            chk("s_ready", 32'(s_ready), 32'(m_sr));
            chk("dout_valid", 32'(dout_valid), 32'(m_dv));
            chk("dout", 32'(dout), 32'(m_dout));
            chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
            chk("udf_err", 32'(udf_err), 32'(m_udf));
        end
    end

    // Apply inputs for one edge, then settle just after it.
    task automatic step(input bit w, input bit r, input logic [WIDTH-1:0] d);
        wr_en = w; rd_en = r; din = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; din = 8'h00; wr_en = 1'b0; rd_en = 1'b0;
        m_count = 5'd4; s_count = 5'd16;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk_en = 1'b1;
        chk("rst data_count", 32'(data_count), 32'd0);
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst m_ready", 32'(m_ready), 32'd0);
        chk("rst s_ready", 32'(s_ready), 32'd1);
        rst = 1'b0;
        step(1'b0, 1'b0, 8'h00);

        // 1. watermarks during first writes
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0, 8'(i));
            chk("t1 count", 32'(data_count), 32'(i));
            chk("t1 m_ready", 32'(m_ready), 32'(i == 4));
            chk("t1 s_ready", 32'(s_ready), 32'd0);
        end

        // 2. fill, overflow, drain
        for (int i = 5; i <= 16; i++) step(1'b1, 1'b0, 8'(i));
        chk("t2 full", 32'(full), 32'd1);
        step(1'b1, 1'b0, 8'h11);
        chk("t2 ovf count", 32'(data_count), 32'd16);
        chk("t2 ovf_err", 32'(ovf_err), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("t2 dout", 32'(dout), 32'(i));
            chk("t2 dout_valid", 32'(dout_valid), 32'd1);
        end
        step(1'b0, 1'b0, 8'h00);
        chk("t2 empty", 32'(empty), 32'd1);
        chk("t2 dv idle", 32'(dout_valid), 32'd0);

        // 3. steady wr+rd at count 8 across pointer wrap
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 8'(8'h28 + i));
            chk("t3 count", 32'(data_count), 32'd8);
            chk("t3 dout", 32'(dout), 32'(8'h20 + i));
        end

        // 4. underflow then rst clears errors
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);
        chk("t4 last dout", 32'(dout), 32'h3B);
        step(1'b0, 1'b1, 8'h00);
        chk("t4 udf_err", 32'(udf_err), 32'd1);
        chk("t4 udf dv", 32'(dout_valid), 32'd0);
        chk("t4 udf dout", 32'(dout), 32'h3B);
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        chk("t4 ovf clr", 32'(ovf_err), 32'd0);
        chk("t4 udf clr", 32'(udf_err), 32'd0);

        // 5. clr with wr+rd at count 10
        step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        chk("t5 pre count", 32'(data_count), 32'd10);
        clr = 1'b1;
        step(1'b1, 1'b1, 8'h77);
        clr = 1'b0;
        chk("t5 count", 32'(data_count), 32'd0);
        chk("t5 empty", 32'(empty), 32'd1);
        chk("t5 dv", 32'(dout_valid), 32'd0);
        chk("t5 udf kept", 32'(udf_err), 32'd1);
        chk("t5 ovf kept", 32'(ovf_err), 32'd0);
        step(1'b1, 1'b0, 8'h55);
        step(1'b0, 1'b1, 8'h00);
        chk("t5 no stale", 32'(dout), 32'h55);

        // 6. watermark corners
        m_count = 5'd0;
        step(1'b0, 1'b0, 8'h00);
        chk("t6 m0 ready", 32'(m_ready), 32'd1);
        s_count = 5'd17;
        step(1'b0, 1'b0, 8'h00);
        chk("t6 s17 ready", 32'(s_ready), 32'd0);
        m_count = 5'd4;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
        chk("t6 m4 at 3", 32'(m_ready), 32'd0);
        m_count = 5'd2;
        step(1'b0, 1'b0, 8'h00);
        chk("t6 m2 at 3", 32'(m_ready), 32'd1);
        s_count = 5'd0;
        step(1'b0, 1'b0, 8'h00);
        chk("t6 s0 ready", 32'(s_ready), 32'd1);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
